// File: rtl/vscpu_loader_ctrl.sv
// Loader/sequencer for a small CPU: streams a program from the host into
// RAM, releases the CPU from reset, counts run cycles and detects halt when
// the program counter stops moving.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | CPU held in reset, RAM address follows dbg_addr for readback
// LOAD  | host words written to RAM at consecutive addresses from 0
// RUN   | CPU released, RAM port muxed to the CPU, cycles counting
// DONE  | pc stayed stable long enough, CPU held in reset, cycles frozen
module vscpu_loader_ctrl #(
    parameter int SIZE     = 14,
    parameter int HALT_CYC = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_start,
    input  logic [SIZE-1:0] ld_count,
    input  logic            ld_valid,
    input  logic [31:0]     ld_data,
    output logic            ld_ready,
    input  logic            abort,
    input  logic [SIZE-1:0] dbg_addr,
    input  logic            cpu_wrEn,
    input  logic [SIZE-1:0] cpu_addr,
    input  logic [31:0]     cpu_data,
    input  logic [SIZE-1:0] cpu_pc,
    output logic            cpu_rst,
    output logic            ram_wrEn,
    output logic [SIZE-1:0] ram_addr,
    output logic [31:0]     ram_data,
    output logic            busy,
    output logic            done,
    output logic [31:0]     cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Wide enough to hold HALT_CYC-1 for any legal HALT_CYC >= 1.
    localparam int STW = (HALT_CYC > 1) ? $clog2(HALT_CYC + 1) : 1;
    localparam logic [STW-1:0]  HALT_LAST = STW'(HALT_CYC - 1);
    localparam logic [STW-1:0]  ST_ONE    = STW'(1);
    localparam logic [SIZE-1:0] A_ONE     = SIZE'(1);

    state_t          state_q, state_d;
    logic [SIZE-1:0] addr_q, addr_d;
    logic [SIZE-1:0] cnt_q, cnt_d;
    logic [STW-1:0]  stable_q, stable_d;
    logic [SIZE-1:0] pc_q;
    logic [31:0]     cycles_q, cycles_d;
    logic            pc_eq;

    assign pc_eq = (pc_q == cpu_pc);

    // State and datapath registers; pc copy tracks cpu_pc every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            pc_q     <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            pc_q     <= cpu_pc;
            cycles_q <= cycles_d;
        end
    end

    // Next-state logic; abort overrides whatever the state decided.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        cycles_d = cycles_q;
        case (state_q)
            IDLE, DONE: begin
                if (ld_start) begin
                    addr_d   = '0;
                    cnt_d    = ld_count;
                    cycles_d = '0;
                    stable_d = '0;
                    state_d  = (ld_count != '0) ? LOAD : RUN;
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    addr_d = addr_q + A_ONE;
                    if (addr_q == cnt_q - A_ONE) begin
                        state_d  = RUN;
                        stable_d = '0;
                    end
                end
            end
            RUN: begin
                if (cycles_q != 32'hFFFF_FFFF) begin
                    cycles_d = cycles_q + 32'd1;
                end
                if (pc_eq) begin
                    if (stable_q == HALT_LAST) begin
                        state_d = DONE;
                    end else begin
                        stable_d = stable_q + ST_ONE;
                    end
                end else begin
                    stable_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    // Output decode: RAM port owner and status flags, all from state.
    always_comb begin
        ld_ready = 1'b0;
        cpu_rst  = 1'b1;
        ram_wrEn = 1'b0;
        ram_addr = dbg_addr;
        ram_data = '0;
        case (state_q)
            LOAD: begin
                ld_ready = 1'b1;
                ram_addr = addr_q;
                if (ld_valid) begin
                    ram_wrEn = 1'b1;
                    ram_data = ld_data;
                end
            end
            RUN: begin
                cpu_rst  = 1'b0;
                ram_wrEn = cpu_wrEn;
                ram_addr = cpu_addr;
                ram_data = cpu_data;
            end
            default: begin
                ram_addr = dbg_addr;
            end
        endcase
    end

    assign busy   = (state_q == LOAD) || (state_q == RUN);
    assign done   = (state_q == DONE);
    assign cycles = cycles_q;

endmodule

// File: tb/tb_vscpu_loader_ctrl.sv
// Directed bench for vscpu_loader_ctrl with a small behavioural RAM.
module tb_vscpu_loader_ctrl;

    localparam int SIZE = 14;

    logic            clk;
    logic            rst;
    logic            ld_start;
    logic [SIZE-1:0] ld_count;
    logic            ld_valid;
    logic [31:0]     ld_data;
    logic            ld_ready;
    logic            abort;
    logic [SIZE-1:0] dbg_addr;
    logic            cpu_wrEn;
    logic [SIZE-1:0] cpu_addr;
    logic [31:0]     cpu_data;
    logic [SIZE-1:0] cpu_pc;
    logic            cpu_rst;
    logic            ram_wrEn;
    logic [SIZE-1:0] ram_addr;
    logic [31:0]     ram_data;
    logic            busy;
    logic            done;
    logic [31:0]     cycles;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:63];

    vscpu_loader_ctrl #(.SIZE(SIZE), .HALT_CYC(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_start (ld_start),
        .ld_count (ld_count),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .abort    (abort),
        .dbg_addr (dbg_addr),
        .cpu_wrEn (cpu_wrEn),
        .cpu_addr (cpu_addr),
        .cpu_data (cpu_data),
        .cpu_pc   (cpu_pc),
        .cpu_rst  (cpu_rst),
        .ram_wrEn (ram_wrEn),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .busy     (busy),
        .done     (done),
        .cycles   (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wrEn && ram_addr < 64) begin
            mem[ram_addr[5:0]] <= ram_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; ld_start = 1'b0; ld_count = '0; ld_valid = 1'b0; ld_data = '0;
        abort = 1'b0; dbg_addr = 14'd7; cpu_wrEn = 1'b0; cpu_addr = '0;
        cpu_data = '0; cpu_pc = '0;
        #3;
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wren", 32'(ram_wrEn), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd7);
        chk("rst_data", ram_data, 32'd0);
        chk("rst_cycles", cycles, 32'd0);
        @(negedge clk) rst = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Load three words with gaps.
        ld_start = 1'b1; ld_count = 14'd3;
        #1 chk("idle_start_wren", 32'(ram_wrEn), 32'd0);
        tick();
        ld_start = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_ready", 32'(ld_ready), 32'd1);
        chk("load_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("load_cycles", cycles, 32'd0);
        ld_valid = 1'b0;
        #1 chk("load_gap_wren", 32'(ram_wrEn), 32'd0);
        tick();
        ld_valid = 1'b1; ld_data = 32'hA;
        #1;
        chk("load_w0_wren", 32'(ram_wrEn), 32'd1);
        chk("load_w0_addr", 32'(ram_addr), 32'd0);
        chk("load_w0_data", ram_data, 32'hA);
        tick();
        ld_valid = 1'b0;
        tick();
        tick();
        ld_valid = 1'b1; ld_data = 32'hB;
        tick();
        ld_valid = 1'b0;
        tick();
        ld_valid = 1'b1; ld_data = 32'hC;
        #1;
        chk("load_w2_addr", 32'(ram_addr), 32'd2);
        chk("load_w2_cpu_rst", 32'(cpu_rst), 32'd1);
        tick();
        ld_valid = 1'b0;
        chk("run_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("run_busy", 32'(busy), 32'd1);
        chk("mem0", mem[0], 32'hA);
        chk("mem1", mem[1], 32'hB);
        chk("mem2", mem[2], 32'hC);

        // CPU owns the RAM port in RUN.
        cpu_wrEn = 1'b1; cpu_addr = 14'd20; cpu_data = 32'h1234;
        #1;
        chk("run_pass_wren", 32'(ram_wrEn), 32'd1);
        chk("run_pass_addr", 32'(ram_addr), 32'd20);
        chk("run_pass_data", ram_data, 32'h1234);
        chk("run_cycles0", cycles, 32'd0);
        cpu_wrEn = 1'b0; cpu_addr = '0; cpu_data = '0;

        // pc moves every 3 cycles, then sticks at 5.
        for (int g = 1; g <= 4; g++) begin
            for (int r = 0; r < 3; r++) begin
                cpu_pc = 14'(g);
                tick();
            end
        end
        chk("run_cycles12", cycles, 32'd12);
        chk("run_still_busy", 32'(busy), 32'd1);
        cpu_pc = 14'd5;
        for (int i = 0; i < 16; i++) tick();
        chk("halt_pre_busy", 32'(busy), 32'd1);
        chk("halt_pre_done", 32'(done), 32'd0);
        tick();
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_busy", 32'(busy), 32'd0);
        chk("halt_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("halt_cycles", cycles, 32'd29);
        tick(); tick(); tick();
        chk("done_cycles_frozen", cycles, 32'd29);
        chk("done_hold", 32'(done), 32'd1);
        dbg_addr = 14'd2;
        #1;
        chk("done_dbg_addr", 32'(ram_addr), 32'd2);
        chk("done_wren", 32'(ram_wrEn), 32'd0);

        // Zero-length load goes straight to RUN.
        ld_start = 1'b1; ld_count = 14'd0; cpu_pc = 14'd100;
        tick();
        ld_start = 1'b0;
        chk("zero_busy", 32'(busy), 32'd1);
        chk("zero_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("zero_cycles", cycles, 32'd0);
        chk("zero_ready", 32'(ld_ready), 32'd0);
        chk("zero_done", 32'(done), 32'd0);

        // ld_start in RUN is ignored.
        cpu_pc = 14'd101;
        tick();
        ld_start = 1'b1; ld_count = 14'd5; cpu_pc = 14'd102;
        tick();
        ld_start = 1'b0;
        chk("run_start_busy", 32'(busy), 32'd1);
        chk("run_start_ready", 32'(ld_ready), 32'd0);
        chk("run_start_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("run_start_cycles", cycles, 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_run_busy", 32'(busy), 32'd0);
        chk("abort_run_done", 32'(done), 32'd0);
        chk("abort_run_cpu_rst", 32'(cpu_rst), 32'd1);

        // Abort after one of four words.
        ld_start = 1'b1; ld_count = 14'd4;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 32'h11;
        tick();
        ld_valid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_load_busy", 32'(busy), 32'd0);
        chk("abort_load_ready", 32'(ld_ready), 32'd0);
        chk("abort_load_mem0", mem[0], 32'h11);
        chk("abort_load_mem1", mem[1], 32'hB);

        // A word presented in the abort cycle is still written.
        ld_start = 1'b1; ld_count = 14'd2;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 32'h33; abort = 1'b1;
        #1 chk("abort_valid_wren", 32'(ram_wrEn), 32'd1);
        tick();
        ld_valid = 1'b0; abort = 1'b0;
        chk("abort_valid_busy", 32'(busy), 32'd0);
        chk("abort_valid_mem0", mem[0], 32'h33);

        // Abort beats ld_start.
        ld_start = 1'b1; ld_count = 14'd3; abort = 1'b1;
        tick();
        ld_start = 1'b0; abort = 1'b0;
        chk("abort_prio_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of RUN.
        ld_start = 1'b1; ld_count = 14'd0;
        tick();
        ld_start = 1'b0;
        tick();
        cpu_wrEn = 1'b1; cpu_addr = 14'd30; cpu_data = 32'h55;
        #1 chk("pre_rst_wren", 32'(ram_wrEn), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_wren", 32'(ram_wrEn), 32'd0);
        chk("arst_addr", 32'(ram_addr), 32'd2);
        chk("arst_data", ram_data, 32'd0);
        chk("arst_cycles", cycles, 32'd0);
        @(negedge clk) rst = 1'b1;
        cpu_wrEn = 1'b0; cpu_addr = '0; cpu_data = '0;
        tick();

        // ld_start during LOAD must not restart the load.
        ld_start = 1'b1; ld_count = 14'd2;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 32'h77;
        tick();
        ld_start = 1'b1; ld_count = 14'd9; ld_data = 32'h78;
        #1 chk("reload_ignored_addr", 32'(ram_addr), 32'd1);
        tick();
        ld_start = 1'b0; ld_valid = 1'b0;
        chk("reload_run_busy", 32'(busy), 32'd1);
        chk("reload_run_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("reload_mem0", mem[0], 32'h77);
        chk("reload_mem1", mem[1], 32'h78);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vscpu_loader_ctrl.md
VSCPU_LOADER_CTRL -- requirements
Module: vscpu_loader_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 14, RAM address width in bits.
REQ-002 SHALL have parameter HALT_CYC, default 16, number of consecutive cycles with an unchanged pCounter that marks the program as halted.
REQ-003 One clock, clk; reset rst is asynchronous and active-low.
REQ-004 Ports SHALL be, one per line:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset
- ld_start  input  1  one-cycle pulse that begins a program load
- ld_count  input  SIZE  number of words to load, sampled on ld_start
- ld_valid  input  1  host word valid
- ld_data  input  32  host word
- ld_ready  output  1  controller accepts a word this cycle
- abort  input  1  synchronous return to IDLE
- dbg_addr  input  SIZE  read address driven to RAM in IDLE/DONE
- cpu_wrEn  input  1  CPU write enable
- cpu_addr  input  SIZE  CPU RAM address
- cpu_data  input  32  CPU write data
- cpu_pc  input  SIZE  CPU pCounter
- cpu_rst  output  1  active-high CPU reset
- ram_wrEn  output  1  RAM write enable
- ram_addr  output  SIZE  RAM address
- ram_data  output  32  RAM write data
- busy  output  1  high in LOAD or RUN
- done  output  1  high in DONE
- cycles  output  32  RUN cycle count of the last/current run

Function
REQ-005 The FSM SHALL have exactly four states: IDLE=0, LOAD=1, RUN=2, DONE=3.
REQ-006 IDLE/DONE + ld_start=1: ld_count!=0 -> LOAD; ld_count==0 -> RUN; in both cases load address reg = 0, ld_count latched, cycles cleared to 0.
REQ-007 ld_start in LOAD or RUN SHALL be ignored.
REQ-008 In LOAD: ld_ready=1 (combinational from state); when ld_valid=1, ram_wrEn=1, ram_addr=load address, ram_data=ld_data in the same cycle, and the load address increments on the next edge.
REQ-009 Accepting the word at load address == latched count-1 SHALL move to RUN on that edge; no other word is written.
REQ-010 In IDLE, LOAD and DONE cpu_rst=1; in RUN cpu_rst=0.
REQ-011 In RUN: ram_wrEn/ram_addr/ram_data = cpu_wrEn/cpu_addr/cpu_data (pure combinational mux, zero latency).
REQ-012 In IDLE and DONE: ram_addr=dbg_addr, ram_wrEn=0, ram_data=0.
REQ-013 In RUN: cycles increments by 1 every clock and saturates at 32'hFFFF_FFFF.
REQ-014 In RUN: a registered copy of cpu_pc is compared with cpu_pc each cycle; if equal, a stable counter increments, otherwise it clears to 0; the stable counter clears on entry to RUN.
REQ-015 When the stable counter equals HALT_CYC-1 and pc is equal again, the FSM SHALL move to DONE on that edge (exactly HALT_CYC equal comparisons).
REQ-016 cycles SHALL hold its value in DONE and IDLE until the next ld_start.
REQ-017 abort=1 from any state SHALL force IDLE on the next edge; abort has priority over ld_start and over all other transitions; a word presented with ld_valid in the abort cycle is still written.
REQ-018 busy = (state==LOAD || state==RUN); done = (state==DONE); both combinational from state.

Reset
REQ-019 rst=0 SHALL asynchronously set state=IDLE, load address=0, latched count=0, stable counter=0, pc copy=0, cycles=0.
REQ-020 During reset: cpu_rst=1, ld_ready=0, busy=0, done=0, ram_wrEn=0, ram_addr=dbg_addr, ram_data=0.
REQ-021 Reset mid-LOAD or mid-RUN SHALL abandon the operation; RAM contents already written are not cleared.

Verification
REQ-022 ld_start with ld_count=3, three words 0xA, 0xB, 0xC with valid gaps -> RAM[0..2]=A,B,C; RUN entered the edge after the third accept; cpu_rst falls then.
REQ-023 RUN with cpu_pc changing every 3 cycles then stuck at 5 -> DONE exactly 16 cycles after pc first equals 5 on the registered copy; done=1, cpu_rst=1, cycles frozen.
REQ-024 ld_start with ld_count=0 -> RUN next cycle, no RAM write, cycles starts at 0.
REQ-025 abort asserted in LOAD after 1 of 4 words -> IDLE next edge, ld_ready=0, RAM[0] written, RAM[1] untouched.
REQ-026 rst low mid-RUN -> outputs at reset values immediately (no clock edge); after release, ld_start during prior LOAD-like traffic is accepted only from IDLE.
REQ-027 ld_start pulsed while in RUN -> ignored, cycles keeps counting, no state change.
